// File: rtl/dac_spi_ctrl_pkg.sv
// Shared types and constants for the DAC SPI responder.
package dac_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  localparam logic [CMD_W-1:0] DAC_CMD = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    CS_HIGH,
    ACK
  } dac_state_t;

endpackage

// File: rtl/dac_spi_ctrl_if.sv
// Filter-to-DAC conversion request/acknowledge handshake.
interface dac_spi_ctrl_if #(
  parameter int unsigned IN_W = 16
);

  logic            dac_conv_req;
  logic [IN_W-1:0] filt_data;
  logic            dac_conv_ack;

  modport master (
    output dac_conv_req,
    output filt_data,
    input  dac_conv_ack
  );

  modport slave (
    input  dac_conv_req,
    input  filt_data,
    output dac_conv_ack
  );

endinterface

// File: rtl/dac_spi_ctrl_tick_gen.sv
// SCLK half-period divider: one-cycle enable every CLK_DIV clocks, restarted by i_clr.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_half_tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLK_DIV - 1);
  // After a clear the count reads 0, then reloads; the tick lands on the last cycle of each period
  localparam logic [CNT_W-1:0] TICK_VAL = (CLK_DIV > 1) ? CNT_W'(1) : CNT_W'(0);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= LOAD_VAL;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_half_tick_c = (r_cnt == TICK_VAL);

endmodule

// File: rtl/dac_spi_ctrl.sv
// DAC SPI responder: latches filter output, converts to offset binary, shifts a 16-bit frame.
// Optional rounding with saturation when DAC_ROUND_EN is defined; truncation otherwise.
module dac_spi_ctrl
  import dac_pkg::*;
#(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned DAC_W   = 12,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  dac_spi_ctrl_if.slave      bus,
  output logic               dac_cs_n,
  output logic               dac_sclk,
  output logic               dac_mosi
);

  localparam int unsigned SHIFT_AMT = IN_W - DAC_W;
  localparam logic [DAC_W-1:0] SIGN_FLIP = {1'b1, {(DAC_W-1){1'b0}}};

  dac_state_t         r_state;
  dac_state_t         w_state_nxt;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] w_shift_nxt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BIT_W-1:0]   w_bit_cnt_nxt;
  logic               r_cs_n;
  logic               w_cs_n_nxt;
  logic               r_sclk;
  logic               w_sclk_nxt;
  logic               r_mosi;
  logic               w_mosi_nxt;
  logic               r_ack;
  logic               w_ack_nxt;

  logic               w_tick;
  logic               w_last_bit;
  logic [IN_W-1:0]    w_src;
  logic [DAC_W-1:0]   w_code;
  logic [FRAME_W-1:0] w_frame;

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk           (clk),
    .reset         (reset),
    .i_clr         (r_state == IDLE),
    .o_half_tick_c (w_tick)
  );

`ifdef DAC_ROUND_EN
  localparam logic [IN_W:0] RND_VAL = (IN_W+1)'(1) << (SHIFT_AMT - 1);
  logic [IN_W:0] w_sum;
  logic          w_ovf;

  // Adding a positive constant can only overflow towards +max
  assign w_sum = {bus.filt_data[IN_W-1], bus.filt_data} + RND_VAL;
  assign w_ovf = w_sum[IN_W] ^ w_sum[IN_W-1];
  assign w_src = w_ovf ? {1'b0, {(IN_W-1){1'b1}}} : w_sum[IN_W-1:0];
`else
  assign w_src = bus.filt_data;
`endif

  assign w_code     = DAC_W'(w_src >> SHIFT_AMT) ^ SIGN_FLIP;
  assign w_frame    = {DAC_CMD, w_code};
  assign w_last_bit = (r_bit_cnt == BIT_W'(FRAME_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.dac_conv_req) w_state_nxt = SETUP;
      SETUP:   if (w_tick) w_state_nxt = SHIFT;
      SHIFT:   if (w_tick && !r_sclk && w_last_bit) w_state_nxt = CS_HIGH;
      CS_HIGH: if (w_tick) w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values; outputs are registered below
  always_comb begin
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_cs_n_nxt    = r_cs_n;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_ack_nxt     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.dac_conv_req) begin
          w_shift_nxt   = w_frame;
          w_bit_cnt_nxt = '0;
          w_cs_n_nxt    = 1'b0;
          w_mosi_nxt    = w_frame[FRAME_W-1];
        end
      end
      SETUP: begin
        if (w_tick) w_sclk_nxt = 1'b1;
      end
      SHIFT: begin
        if (w_tick) begin
          if (r_sclk) begin
            w_sclk_nxt = 1'b0;
            if (!w_last_bit) begin
              w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
              w_mosi_nxt  = r_shift[FRAME_W-2];
            end
          end else if (w_last_bit) begin
            w_cs_n_nxt = 1'b1;
          end else begin
            w_sclk_nxt    = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      CS_HIGH: begin
        if (w_tick) w_ack_nxt = 1'b1;
      end
      ACK: begin
        w_mosi_nxt = 1'b0;
      end
      default: begin
        w_cs_n_nxt = 1'b1;
        w_sclk_nxt = 1'b0;
        w_mosi_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_ack     <= w_ack_nxt;
    end
  end

  assign dac_cs_n         = r_cs_n;
  assign dac_sclk         = r_sclk;
  assign dac_mosi         = r_mosi;
  assign bus.dac_conv_ack = r_ack;

endmodule
